// File: rtl/ahb_burst_master_if.sv
// Command, write-stream, read-return and AHB-Lite bus signals of the burst master.
interface ahb_burst_master_if #(
    parameter int unsigned LEN_W = 5
);
    // command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_addr;
    logic             cmd_write;
    logic [LEN_W-1:0] cmd_len;

    // write-data stream
    logic [31:0]      wr_data;
    logic             wr_valid;
    logic             wr_ready;

    // read return and completion
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             done;

    // AHB-Lite
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [2:0]       HBURST;
    logic [31:0]      HWDATA;
    logic [31:0]      HRDATA;
    logic             HREADY;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_len,
        input  wr_data, wr_valid,
        input  HRDATA, HREADY,
        output cmd_ready, wr_ready, rd_data, rd_valid, done,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_len,
        output wr_data, wr_valid,
        output HRDATA, HREADY,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );
endinterface

// File: rtl/ahb_burst_master.sv
// AHB-Lite INCR burst master: turns a command into a pipelined word burst,
// pulls write data from a valid/ready stream and returns read beats as pulses.
module ahb_burst_master #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5
) (
    input logic                HCLK,
    input logic                HRESETn,
    ahb_burst_master_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_LAST
    } state_t;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    state_t           state;
    state_t           state_nxt;
    htrans_t          htrans_c;
    logic             addr_acc;
    logic             cmd_ready_c;

    logic [31:0]      haddr;
    logic             hwrite;
    logic [2:0]       hburst;
    logic [31:0]      hwdata;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             done;
    logic [LEN_W-1:0] beats_rem;   // beats still to issue after the one on HADDR
    logic             first;       // HADDR holds the first beat of the burst
    logic             dp_active;   // a data phase is in progress
    logic             dp_write;    // direction of that data phase
    logic [LEN_W-1:0] len_eff;

    // Clamp the requested length into 1..MAX_LEN
    always_comb begin
        len_eff = bus.cmd_len;
        if (bus.cmd_len == '0) begin
            len_eff = LEN_W'(1);
        end else if (bus.cmd_len > LEN_W'(MAX_LEN)) begin
            len_eff = LEN_W'(MAX_LEN);
        end
    end

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, transfer type and address-phase acceptance
    always_comb begin
        state_nxt   = state;
        htrans_c    = HT_IDLE;
        addr_acc    = 1'b0;
        cmd_ready_c = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                // A write beat is only issued once its data is on the stream;
                // until then the first beat idles and later beats insert BUSY.
                if (!hwrite || bus.wr_valid) begin
                    htrans_c = (first || haddr[9:0] == '0) ? HT_NONSEQ : HT_SEQ;
                end else begin
                    htrans_c = first ? HT_IDLE : HT_BUSY;
                end
                addr_acc = bus.HREADY && htrans_c[1];
                if (addr_acc && beats_rem == '0) begin
                    state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                if (bus.HREADY) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address/data pipeline, read capture and completion pulses
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr     <= '0;
            hwrite    <= 1'b0;
            hburst    <= '0;
            hwdata    <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            beats_rem <= '0;
            first     <= 1'b0;
            dp_active <= 1'b0;
            dp_write  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;

            if (bus.HREADY) begin
                // The data phase in flight (if any) completes on this edge;
                // a beat accepted on the same edge opens the next one.
                if (dp_active && !dp_write) begin
                    rd_data  <= bus.HRDATA;
                    rd_valid <= 1'b1;
                end
                dp_active <= addr_acc;
            end

            if (state == S_LAST && bus.HREADY) begin
                done <= 1'b1;
            end

            if (addr_acc) begin
                dp_write <= hwrite;
                first    <= 1'b0;
                if (hwrite) begin
                    hwdata <= bus.wr_data;
                end
                if (beats_rem != '0) begin
                    haddr     <= haddr + 32'd4;
                    beats_rem <= beats_rem - 1'b1;
                end
            end

            if (state == S_IDLE && bus.cmd_valid) begin
                haddr     <= bus.cmd_addr & ~32'h3;
                hwrite    <= bus.cmd_write;
                hburst    <= (len_eff == LEN_W'(1)) ? 3'b000 : 3'b001;
                beats_rem <= len_eff - 1'b1;
                first     <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.wr_ready  = addr_acc && hwrite;
    assign bus.rd_data   = rd_data;
    assign bus.rd_valid  = rd_valid;
    assign bus.done      = done;
    assign bus.HADDR     = haddr;
    assign bus.HTRANS    = htrans_c;
    assign bus.HWRITE    = hwrite;
    assign bus.HSIZE     = 3'b010;
    assign bus.HBURST    = hburst;
    assign bus.HWDATA    = hwdata;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master with a word-memory slave model and
// scoreboard queues for address beats, write data and read returns.
module tb_ahb_burst_master;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
    } beat_t;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;

    ahb_burst_master_if #(.LEN_W(5)) bus ();

    ahb_burst_master #(.MAX_LEN(16), .LEN_W(5)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    beat_t       aq[$];
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    logic [31:0] src[$];

    int unsigned busy_cnt = 0;
    logic [31:0] busy_addr = '0;
    int unsigned done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Slave memory: word at index i initialised to i-64 (so 0x100 holds 0)
    logic [31:0] mem [0:511];
    logic        s_dp_valid;
    logic        s_dp_write;
    logic [8:0]  s_dp_idx;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_dp_valid <= 1'b0;
            s_dp_write <= 1'b0;
            s_dp_idx   <= '0;
            for (int i = 0; i < 512; i++) mem[i] <= 32'(i) - 32'd64;
        end else if (bus.HREADY) begin
            if (s_dp_valid && s_dp_write) mem[s_dp_idx] <= bus.HWDATA;
            s_dp_valid <= bus.HTRANS[1];
            s_dp_write <= bus.HWRITE;
            s_dp_idx   <= bus.HADDR[10:2];
        end
    end

    assign bus.HRDATA = (s_dp_valid && !s_dp_write) ? mem[s_dp_idx] : 32'h0;

    // Monitor on the falling edge
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (bus.HREADY && bus.HTRANS[1]) begin
                chk("beat_expected", 32'(aq.size() > 0), 32'd1);
                if (aq.size() > 0) begin
                    beat_t b;
                    b = aq.pop_front();
                    chk("haddr", bus.HADDR, b.addr);
                    chk("htrans", 32'(bus.HTRANS), 32'(b.trans));
                    chk("hwrite", 32'(bus.HWRITE), 32'(b.write));
                end
            end
            if (bus.HTRANS == 2'b01) begin
                busy_cnt++;
                busy_addr = bus.HADDR;
            end
            if (bus.HREADY && s_dp_valid && s_dp_write) begin
                chk("wdata_expected", 32'(wq.size() > 0), 32'd1);
                if (wq.size() > 0) chk("hwdata", bus.HWDATA, wq.pop_front());
            end
            if (bus.rd_valid) begin
                chk("rdata_expected", 32'(rq.size() > 0), 32'd1);
                if (rq.size() > 0) chk("rd_data", bus.rd_data, rq.pop_front());
            end
            if (bus.done) done_cnt++;
        end
    end

    // Write-data source with an optional gap after a chosen handshake
    logic        wr_hs = 1'b0;
    int unsigned hs_cnt = 0;
    int unsigned hold = 0;
    int unsigned gap_after = 0;
    int unsigned gap_len = 0;

    always @(negedge HCLK) wr_hs = bus.wr_valid && bus.wr_ready;

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        forever begin
            @(posedge HCLK);
            #1;
            if (wr_hs && src.size() > 0) begin
                void'(src.pop_front());
                hs_cnt++;
                if (hs_cnt == gap_after) hold = gap_len;
            end
            if (hold > 0) begin
                bus.wr_valid = 1'b0;
                hold--;
            end else if (src.size() > 0) begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = src[0];
            end else begin
                bus.wr_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    // Queue the expected beats, write words and read returns of one burst
    task automatic push_burst(input logic [31:0] addr, input logic write,
                              input int unsigned n, input logic [31:0] seed);
        for (int unsigned i = 0; i < n; i++) begin
            logic [31:0] a;
            beat_t b;
            a = addr + 32'(4 * i);
            b.addr  = a;
            b.trans = (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
            b.write = write;
            aq.push_back(b);
            if (write) begin
                wq.push_back(seed + 32'(i));
                src.push_back(seed + 32'(i));
            end else begin
                rq.push_back(32'(a[10:2]) - 32'd64);
            end
        end
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic write, input logic [4:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_write = write;
        bus.cmd_len   = len;
        chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned budget, input logic is_read);
        int unsigned n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            tick();
            n++;
            if (bus.done) begin
                seen = 1'b1;
                if (is_read) chk({tag, "_last_rd_valid"}, 32'(bus.rd_valid), 32'd1);
            end
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned b0;
        int unsigned d0;
        logic found;

        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_len   = '0;
        bus.HREADY    = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
        chk("rst_haddr", bus.HADDR, 32'd0);
        chk("rst_hwdata", bus.HWDATA, 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_hburst", 32'(bus.HBURST), 32'd0);
        HRESETn = 1'b1;
        tick();

        // 1: single write
        push_burst(32'h10, 1'b1, 1, 32'hDEADBEEF);
        send_cmd(32'h10, 1'b1, 5'd1);
        chk("t1_htrans", 32'(bus.HTRANS), 32'h2);
        chk("t1_haddr", bus.HADDR, 32'h10);
        chk("t1_hwrite", 32'(bus.HWRITE), 32'd1);
        chk("t1_hburst", 32'(bus.HBURST), 32'd0);
        tick();
        chk("t1_idle", 32'(bus.HTRANS), 32'd0);
        chk("t1_hwdata", bus.HWDATA, 32'hDEADBEEF);
        chk("t1_no_early_done", 32'(bus.done), 32'd0);
        tick();
        chk("t1_done", 32'(bus.done), 32'd1);
        tick();

        // 2: read len4 @0x100
        push_burst(32'h100, 1'b0, 4, 32'h0);
        send_cmd(32'h100, 1'b0, 5'd4);
        chk("t2_hburst", 32'(bus.HBURST), 32'd1);
        wait_done("t2", 20, 1'b1);
        tick();

        // 3: write len4 @0x20 with a two-cycle wait state on beat 2
        push_burst(32'h20, 1'b1, 4, 32'h3000_0000);
        send_cmd(32'h20, 1'b1, 5'd4);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.HTRANS == 2'b11 && bus.HADDR == 32'h28) found = 1'b1;
            else tick();
        end
        chk("t3_beat2_seen", 32'(found), 32'd1);
        bus.HREADY = 1'b0;
        tick();
        chk("t3_hold_haddr", bus.HADDR, 32'h28);
        chk("t3_hold_htrans", 32'(bus.HTRANS), 32'h3);
        chk("t3_hold_hwrite", 32'(bus.HWRITE), 32'd1);
        chk("t3_hold_hwdata", bus.HWDATA, 32'h3000_0001);
        tick();
        bus.HREADY = 1'b1;
        wait_done("t3", 20, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) chk("t3_mem", mem[8 + i], 32'h3000_0000 + 32'(i));

        // 4: write len4 @0x40, stream stalls three cycles before beat 3
        gap_after = hs_cnt + 2;
        gap_len   = 3;
        b0 = busy_cnt;
        push_burst(32'h40, 1'b1, 4, 32'h4000_0000);
        send_cmd(32'h40, 1'b1, 5'd4);
        wait_done("t4", 30, 1'b0);
        chk("t4_busy_cycles", 32'(busy_cnt - b0), 32'd3);
        chk("t4_busy_haddr", busy_addr, 32'h48);
        tick();
        for (int i = 0; i < 4; i++) chk("t4_mem", mem[16 + i], 32'h4000_0000 + 32'(i));

        // 5: write len4 crossing the 1KB boundary
        push_burst(32'h3F8, 1'b1, 4, 32'h5000_0000);
        send_cmd(32'h3F8, 1'b1, 5'd4);
        wait_done("t5", 20, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) chk("t5_mem", mem[254 + i], 32'h5000_0000 + 32'(i));

        // len 0 is a single beat
        push_burst(32'h104, 1'b0, 1, 32'h0);
        send_cmd(32'h104, 1'b0, 5'd0);
        chk("len0_hburst", 32'(bus.HBURST), 32'd0);
        wait_done("len0", 10, 1'b1);
        tick();

        // len 20 clamps to 16; low address bits ignored
        push_burst(32'h200, 1'b0, 16, 32'h0);
        send_cmd(32'h202, 1'b0, 5'd20);
        chk("clamp_haddr", bus.HADDR, 32'h200);
        wait_done("clamp", 60, 1'b1);
        tick();

        // 6: reset in the middle of a read burst
        push_burst(32'h100, 1'b0, 4, 32'h0);
        send_cmd(32'h100, 1'b0, 5'd4);
        tick();
        d0 = done_cnt;
        HRESETn = 1'b0;
        #1;
        chk("t6_htrans", 32'(bus.HTRANS), 32'd0);
        chk("t6_haddr", bus.HADDR, 32'd0);
        chk("t6_hwdata", bus.HWDATA, 32'd0);
        chk("t6_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        aq.delete();
        wq.delete();
        rq.delete();
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
        tick();
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        push_burst(32'h108, 1'b0, 2, 32'h0);
        send_cmd(32'h108, 1'b0, 5'd2);
        wait_done("t6", 20, 1'b1);
        tick();
        tick();

        chk("aq_empty", 32'(aq.size()), 32'd0);
        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);
        chk("src_empty", 32'(src.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
